// File: rtl/dma_pkg.sv
// Shared DMA-side constants and types for the CNN engine memory-port arbiter.
// Also holds the arbiter FSM state encoding.
package dma_pkg;

  localparam int unsigned DmaDataW     = 16;
  localparam int unsigned DmaAddrW     = 16;
  localparam int unsigned DmaReadWords = 25;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StRead,
    StAck
  } dma_state_e;

  typedef logic [DmaReadWords-1:0][DmaDataW-1:0] dma_rd_data_t;

endpackage

// File: rtl/dma_arbiter_rr.sv
// Combinational round-robin picker: the lowest-indexed request at or above ptr_i wins,
// wrapping around. The result is one-hot, plus the binary index of the winner.
module rr_arbiter #(
  parameter int unsigned NReq = 4,
  localparam int unsigned PtrW = $clog2(NReq)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NReq-1:0] gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            valid_o
);

  logic            found;
  logic [PtrW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NReq; off++) begin
      cand = PtrW'((32'(ptr_i) + off) % NReq);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/dma_arbiter.sv
// Shares the single DMA memory port between CNN engine loaders/storers.
// Round-robin grants with optional locked bursts; captures the read window for the owner.
module dma_arbiter
  import dma_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_W     = DmaDataW,
  parameter int unsigned ADDR_W     = DmaAddrW,
  parameter int unsigned READ_WORDS = DmaReadWords,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_REQ-1:0]                     req,
  input  logic [N_REQ-1:0]                     reqRW,
  input  logic [N_REQ-1:0][ADDR_W-1:0]         reqAddr,
  input  logic [N_REQ-1:0][DATA_W-1:0]         reqWData,
  input  logic [N_REQ-1:0]                     reqLock,
  output logic [N_REQ-1:0]                     gnt,
  output logic [N_REQ-1:0]                     ack,
  output logic [READ_WORDS-1:0][DATA_W-1:0]    rdData,
  output logic                                 busy,
  output logic                                 dmaEnable,
  output logic                                 dmaRW,
  output logic [ADDR_W-1:0]                    dmaAddress,
  output logic [DATA_W-1:0]                    dmaInputData,
  input  logic [READ_WORDS-1:0][DATA_W-1:0]    dmaOutputData
);

  localparam int unsigned PtrW   = $clog2(N_REQ);
  localparam int unsigned BurstW = $clog2(MAX_BURST);
  localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);
  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(N_REQ - 1);

  dma_state_e                         state_q, state_d;
  logic [N_REQ-1:0]                   gnt_q, gnt_d;
  logic [PtrW-1:0]                    owner_q, owner_d;
  logic [PtrW-1:0]                    rr_q, rr_d;
  logic [BurstW-1:0]                  burst_q, burst_d;
  logic [READ_WORDS-1:0][DATA_W-1:0]  rd_data_q, rd_data_d;

  logic                               own_req, own_lock, own_rw, others_req;
  logic [PtrW-1:0]                    owner_next, arb_ptr, arb_idx;
  logic [N_REQ-1:0]                   arb_gnt;
  logic                               arb_valid;

  assign own_req    = req[owner_q];
  assign own_lock   = reqLock[owner_q];
  assign own_rw     = reqRW[owner_q];
  assign others_req = |(req & ~gnt_q);
  assign owner_next = (owner_q == PtrLast) ? '0 : owner_q + PtrW'(1);

  // In ACK the next winner is searched from the slot after the current owner.
  assign arb_ptr = (state_q == StAck) ? owner_next : rr_q;

  rr_arbiter #(
    .NReq (N_REQ)
  ) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (arb_ptr),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    burst_d   = burst_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          state_d = StIssue;
          gnt_d   = arb_gnt;
          owner_d = arb_idx;
          burst_d = '0;
        end
      end
      StIssue: state_d = own_rw ? StRead : StAck;
      StRead: begin
        rd_data_d = dmaOutputData;
        state_d   = StAck;
      end
      StAck: begin
        if (own_req && own_lock && (burst_q < BurstLast)) begin
          state_d = StIssue;
          burst_d = burst_q + BurstW'(1);
        end else if (own_req && own_lock && !others_req) begin
          // Burst limit only matters when someone else is waiting.
          state_d = StIssue;
          burst_d = '0;
        end else begin
          rr_d    = owner_next;
          burst_d = '0;
          if (arb_valid) begin
            state_d = StIssue;
            gnt_d   = arb_gnt;
            owner_d = arb_idx;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      burst_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      burst_q   <= burst_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign gnt          = gnt_q;
  assign ack          = (state_q == StAck) ? gnt_q : '0;
  assign busy         = (state_q != StIdle);
  assign rdData       = rd_data_q;
  assign dmaEnable    = (state_q == StIssue);
  assign dmaRW        = dmaEnable & own_rw;
  assign dmaAddress   = dmaEnable ? reqAddr[owner_q] : '0;
  assign dmaInputData = dmaEnable ? reqWData[owner_q] : '0;

endmodule
